exec_rob_wb_arbiter: RTL and testbench

Arbitrates completion reports from N_UNITS execution units onto the single execute→ROB completion port: ex_valid, ex_val, rob_entry_idx, br_mispred, exception. Uses round-robin grant with a mispredict-priority override so branch recovery reaches the ROB first. Output is registered and drives the execute side of the execute/ROB interface. The ROB always accepts, so the port carries no ready signal.

---
 rtl/exec_rob_wb_arbiter_pkg.sv | 16 +
 rtl/exec_rob_wb_arbiter_picker.sv | 28 ++
 rtl/exec_rob_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_exec_rob_wb_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_rob_wb_arbiter_pkg.sv
// Shared core constants and the execute-to-ROB completion payload type.
package exec_rob_wb_arbiter_pkg;

    localparam int unsigned ROB_ENTRIES  = 32;
    localparam int unsigned ROB_IDX_W    = $clog2(ROB_ENTRIES);
    localparam int unsigned NUM_EX_UNITS = 4;

    // One completion report as produced by an execution unit.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [31:0]          val;
        logic                 br_mispred;
        logic                 exception;
    } exec_wb_t;

endpackage

// File: rtl/exec_rob_wb_arbiter_picker.sv
// Round-robin priority picker: one-hot grant of the first set mask bit
// at or after ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found
);

    // Scan N positions starting at ptr; the first set bit wins.
    always_comb begin
        logic [PW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_rob_wb_arbiter.sv
// Execute-side completion arbiter: round-robin over execution units with
// mispredicting branches given priority, registered onto the ROB port.
module exec_rob_wb_arbiter
    import exec_rob_wb_arbiter_pkg::*;
#(
    parameter int unsigned N_UNITS = NUM_EX_UNITS,
    parameter int unsigned IDX_W   = ROB_IDX_W,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [N_UNITS-1:0]         req_valid,
    output logic [N_UNITS-1:0]         req_ready,
    input  logic [N_UNITS*IDX_W-1:0]   req_rob_idx,
    input  logic [N_UNITS*DATA_W-1:0]  req_val,
    input  logic [N_UNITS-1:0]         req_br_mispred,
    input  logic [N_UNITS-1:0]         req_exception,
    output logic                       ex_valid,
    output logic [DATA_W-1:0]          ex_val,
    output logic [IDX_W-1:0]           rob_entry_idx,
    output logic                       br_mispred,
    output logic                       exception
);

    localparam int unsigned PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]  ex_val_q, ex_val_d;
    logic [IDX_W-1:0]   rob_idx_q, rob_idx_d;
    logic               mp_q, mp_d;
    logic               exc_q, exc_d;

    logic [N_UNITS-1:0] mp_mask;
    logic [N_UNITS-1:0] mp_grant, all_grant, sel_oh;
    logic               mp_found, all_found;
    logic               grant_en, xfer;

    logic [PW-1:0]      sel_idx;
    logic [IDX_W-1:0]   sel_rob;
    logic [DATA_W-1:0]  sel_val;
    logic               sel_mp, sel_exc;

    assign mp_mask = req_valid & req_br_mispred;

    rr_priority_picker #(.N(N_UNITS), .PW(PW)) u_pick_mp (
        .mask  (mp_mask),
        .ptr   (rr_ptr_q),
        .grant (mp_grant),
        .found (mp_found)
    );

    rr_priority_picker #(.N(N_UNITS), .PW(PW)) u_pick_all (
        .mask  (req_valid),
        .ptr   (rr_ptr_q),
        .grant (all_grant),
        .found (all_found)
    );

    assign sel_oh    = mp_found ? mp_grant : all_grant;
    assign grant_en  = rst_n & ~flush;
    assign req_ready = grant_en ? sel_oh : '0;
    // A mispredict hit implies a valid hit, so all_found covers both pickers.
    assign xfer      = grant_en & all_found;

    // Encode the one-hot grant and mux out the winning unit's payload.
    always_comb begin
        sel_idx = '0;
        sel_rob = '0;
        sel_val = '0;
        sel_mp  = 1'b0;
        sel_exc = 1'b0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (sel_oh[i]) begin
                sel_idx = PW'(i);
                sel_rob = req_rob_idx[i*IDX_W +: IDX_W];
                sel_val = req_val[i*DATA_W +: DATA_W];
                sel_mp  = req_br_mispred[i];
                sel_exc = req_exception[i];
            end
        end
    end

    // Next state: capture on transfer, drop valid otherwise, flush clears control.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_val_d   = ex_val_q;
        rob_idx_d  = rob_idx_q;
        mp_d       = mp_q;
        exc_d      = exc_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (xfer) begin
            ex_valid_d = 1'b1;
            ex_val_d   = sel_val;
            rob_idx_d  = sel_rob;
            mp_d       = sel_mp;
            exc_d      = sel_exc;
            if (sel_idx == PW'(N_UNITS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = sel_idx + 1'b1;
            end
        end
    end

    // Output register and round-robin pointer with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_val_q   <= '0;
            rob_idx_q  <= '0;
            mp_q       <= 1'b0;
            exc_q      <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_val_q   <= ex_val_d;
            rob_idx_q  <= rob_idx_d;
            mp_q       <= mp_d;
            exc_q      <= exc_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_val        = ex_val_q;
    assign rob_entry_idx = rob_idx_q;
    assign br_mispred    = mp_q;
    assign exception     = exc_q;

endmodule

// File: tb/tb_exec_rob_wb_arbiter.sv
// Directed self-checking bench for exec_rob_wb_arbiter (4 units).
module tb_exec_rob_wb_arbiter;
    import exec_rob_wb_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = ROB_IDX_W;
    localparam int unsigned DW = 32;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IW-1:0]   req_rob_idx;
    logic [N*DW-1:0]   req_val;
    logic [N-1:0]      req_br_mispred;
    logic [N-1:0]      req_exception;
    logic              ex_valid;
    logic [DW-1:0]     ex_val;
    logic [IW-1:0]     rob_entry_idx;
    logic              br_mispred;
    logic              exception;

    int tests_run;
    int tests_failed;

    exec_rob_wb_arbiter #(.N_UNITS(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rob_idx    (req_rob_idx),
        .req_val        (req_val),
        .req_br_mispred (req_br_mispred),
        .req_exception  (req_exception),
        .ex_valid       (ex_valid),
        .ex_val         (ex_val),
        .rob_entry_idx  (rob_entry_idx),
        .br_mispred     (br_mispred),
        .exception      (exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int unsigned u, input logic v, input exec_wb_t p);
        req_valid[u]           = v;
        req_rob_idx[u*IW +: IW] = p.rob_idx;
        req_val[u*DW +: DW]     = p.val;
        req_br_mispred[u]      = p.br_mispred;
        req_exception[u]       = p.exception;
    endtask

    // Default payload: unit i carries rob_idx 4*i+3 and val 0xC0DE0000+i.
    function automatic exec_wb_t dflt(input int unsigned u);
        exec_wb_t p;
        p.rob_idx    = IW'(4*u + 3);
        p.val        = 32'hC0DE_0000 + u;
        p.br_mispred = 1'b0;
        p.exception  = 1'b0;
        return p;
    endfunction

    task automatic load_defaults(input logic v);
        for (int unsigned i = 0; i < N; i++) set_unit(i, v, dflt(i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        load_defaults(1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                $display("FAIL reset_ready cyc%0d: got %b want 0000", c, req_ready);
                tests_failed++;
            end
            step();
            tests_run++;
            if (ex_valid !== 1'b0 || rob_entry_idx !== '0 || ex_val !== '0) begin
                $display("FAIL reset_out cyc%0d: got v=%b idx=%0d val=%h want 0/0/0", c, ex_valid, rob_entry_idx, ex_val);
                tests_failed++;
            end
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                $display("FAIL rr_ready k%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
                tests_failed++;
            end
            step();
            tests_run++;
            if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(4*(k%4)+3) || ex_val !== 32'hC0DE_0000 + (k%4)) begin
                $display("FAIL rr_out k%0d: got v=%b idx=%0d val=%h want 1/%0d/%h", k, ex_valid, rob_entry_idx, ex_val, 4*(k%4)+3, 32'hC0DE_0000 + (k%4));
                tests_failed++;
            end
        end
        load_defaults(1'b0);
        step();
        tests_run++;
        if (ex_valid !== 1'b0) begin
            $display("FAIL rr_idle: got ex_valid=%b want 0", ex_valid);
            tests_failed++;
        end
    endtask

    task automatic test_mispredict();
        exec_wb_t p;
        p = dflt(2);
        p.rob_idx    = IW'(9);
        p.br_mispred = 1'b1;
        p.exception  = 1'b1;
        set_unit(0, 1'b1, dflt(0));
        set_unit(2, 1'b1, p);
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL mp_ready: got %b want 0100", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(9) || br_mispred !== 1'b1 || exception !== 1'b1) begin
            $display("FAIL mp_out: got v=%b idx=%0d mp=%b ex=%b want 1/9/1/1", ex_valid, rob_entry_idx, br_mispred, exception);
            tests_failed++;
        end
        set_unit(2, 1'b0, dflt(2));
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL mp_next_ready: got %b want 0001", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(3) || br_mispred !== 1'b0 || exception !== 1'b0) begin
            $display("FAIL mp_next_out: got v=%b idx=%0d mp=%b ex=%b want 1/3/0/0", ex_valid, rob_entry_idx, br_mispred, exception);
            tests_failed++;
        end
        load_defaults(1'b0);
    endtask

    task automatic test_single_idle();
        exec_wb_t p;
        p = dflt(3);
        p.val = 32'hDEAD_BEEF;
        set_unit(3, 1'b1, p);
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL single_ready: got %b want 1000", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_val !== 32'hDEAD_BEEF || rob_entry_idx !== IW'(15)) begin
            $display("FAIL single_out: got v=%b val=%h idx=%0d want 1/deadbeef/15", ex_valid, ex_val, rob_entry_idx);
            tests_failed++;
        end
        load_defaults(1'b0);
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_val !== 32'hDEAD_BEEF) begin
            $display("FAIL single_idle: got v=%b val=%h want 0/deadbeef", ex_valid, ex_val);
            tests_failed++;
        end
        set_unit(0, 1'b1, dflt(0));
        set_unit(3, 1'b1, dflt(3));
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL wrap_ready: got %b want 0001", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(3)) begin
            $display("FAIL wrap_out: got v=%b idx=%0d want 1/3", ex_valid, rob_entry_idx);
            tests_failed++;
        end
        load_defaults(1'b0);
        step();
    endtask

    task automatic test_flush();
        set_unit(1, 1'b1, dflt(1));
        step();
        set_unit(2, 1'b1, dflt(2));
        flush = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL flush_ready: got %b want 0000", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b0) begin
            $display("FAIL flush_out: got ex_valid=%b want 0", ex_valid);
            tests_failed++;
        end
        flush = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL flush_after_ready: got %b want 0010", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(7)) begin
            $display("FAIL flush_after_out: got v=%b idx=%0d want 1/7", ex_valid, rob_entry_idx);
            tests_failed++;
        end
        set_unit(1, 1'b0, dflt(1));
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(11)) begin
            $display("FAIL flush_u2_out: got v=%b idx=%0d want 1/11", ex_valid, rob_entry_idx);
            tests_failed++;
        end
        load_defaults(1'b0);
        step();
    endtask

    task automatic test_stall();
        exec_wb_t p1, pm;
        int hits;
        int unsigned mp_units[3];
        logic [3:0] mp_ready[3];
        logic [IW-1:0] mp_rob[3];
        hits = 0;
        mp_units[0] = 3; mp_units[1] = 2; mp_units[2] = 0;
        mp_ready[0] = 4'b1000; mp_ready[1] = 4'b0100; mp_ready[2] = 4'b0001;
        mp_rob[0] = IW'(15); mp_rob[1] = IW'(11); mp_rob[2] = IW'(3);
        p1 = dflt(1);
        p1.rob_idx = IW'(5);
        set_unit(1, 1'b1, p1);
        for (int c = 0; c < 3; c++) begin
            pm = dflt(mp_units[c]);
            pm.br_mispred = 1'b1;
            set_unit(mp_units[c], 1'b1, pm);
            #1;
            tests_run++;
            if (req_ready !== mp_ready[c]) begin
                $display("FAIL stall_ready c%0d: got %b want %b", c, req_ready, mp_ready[c]);
                tests_failed++;
            end
            step();
            if (ex_valid && rob_entry_idx == IW'(5)) hits++;
            tests_run++;
            if (ex_valid !== 1'b1 || rob_entry_idx !== mp_rob[c] || br_mispred !== 1'b1) begin
                $display("FAIL stall_out c%0d: got v=%b idx=%0d mp=%b want 1/%0d/1", c, ex_valid, rob_entry_idx, br_mispred, mp_rob[c]);
                tests_failed++;
            end
            set_unit(mp_units[c], 1'b0, dflt(mp_units[c]));
        end
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL stall_win_ready: got %b want 0010", req_ready);
            tests_failed++;
        end
        step();
        if (ex_valid && rob_entry_idx == IW'(5)) hits++;
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(5) || br_mispred !== 1'b0) begin
            $display("FAIL stall_win_out: got v=%b idx=%0d mp=%b want 1/5/0", ex_valid, rob_entry_idx, br_mispred);
            tests_failed++;
        end
        load_defaults(1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            if (ex_valid && rob_entry_idx == IW'(5)) hits++;
        end
        tests_run++;
        if (hits !== 1) begin
            $display("FAIL stall_count: got %0d completions for idx5 want 1", hits);
            tests_failed++;
        end
    endtask

    task automatic test_reset_midstream();
        set_unit(0, 1'b1, dflt(0));
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL midrst_ready: got %b want 0000", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || rob_entry_idx !== '0 || ex_val !== '0) begin
            $display("FAIL midrst_out: got v=%b idx=%0d val=%h want 0/0/0", ex_valid, rob_entry_idx, ex_val);
            tests_failed++;
        end
        rst_n = 1'b1;
        set_unit(2, 1'b1, dflt(2));
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL midrst_after_ready: got %b want 0001", req_ready);
            tests_failed++;
        end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || rob_entry_idx !== IW'(3)) begin
            $display("FAIL midrst_after_out: got v=%b idx=%0d want 1/3", ex_valid, rob_entry_idx);
            tests_failed++;
        end
        load_defaults(1'b0);
        step();
        tests_run++;
        if (ex_valid !== 1'b0) begin
            $display("FAIL midrst_idle: got ex_valid=%b want 0", ex_valid);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        req_valid      = '0;
        req_rob_idx    = '0;
        req_val        = '0;
        req_br_mispred = '0;
        req_exception  = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        test_reset();
        test_round_robin();
        test_mispredict();
        test_single_idle();
        test_flush();
        test_stall();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
